// File: rtl/pipeline_hazard_ctrl_pkg.sv
// ============================================================================
// Module      : pipeline_hazard_ctrl_pkg
// Description : Shared types for the pipeline hazard controller: FSM state,
//               forwarding select encoding and register-address width.
//               Optional feature macro: HAZARD_FORWARDING_EN
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipeline_hazard_ctrl_pkg;

    localparam int REG_ADDR = 5;
    localparam int CNT_W    = 16;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        FLUSH   = 2'd1,
        MEMWAIT = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_EX = 2'b01,
        FWD_MA = 2'b10
    } fwd_sel_t;

endpackage

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl_hazard_compare.sv
// ============================================================================
// Module      : hazard_compare
// Description : Per-operand RAW comparison against EX and MA destinations;
//               yields the forwarding select and a stall request.
//               Optional feature macro: HAZARD_FORWARDING_EN
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_compare
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic [REG_ADDR-1:0] i_rs,
    input  logic                i_rs_used,
    input  logic [REG_ADDR-1:0] i_ex_rd,
    input  logic                i_ex_reg_wr,
    input  logic                i_ex_mem_rd,
    input  logic [REG_ADDR-1:0] i_ma_rd,
    input  logic                i_ma_reg_wr,
    output fwd_sel_t            o_fwd_sel,
    output logic                o_stall_req
);

    logic w_rs_nz;
    logic w_ex_match;
    logic w_ma_match;

    // rs != 0 together with equality also excludes rd == x0
    assign w_rs_nz    = (i_rs != '0);
    assign w_ex_match = w_rs_nz && i_ex_reg_wr && (i_ex_rd == i_rs);
    assign w_ma_match = w_rs_nz && i_ma_reg_wr && (i_ma_rd == i_rs);

`ifdef HAZARD_FORWARDING_EN
    // A load in EX has no result yet, so only a non-load EX producer forwards
    assign o_stall_req = i_rs_used && w_ex_match && i_ex_mem_rd;

    always_comb begin
        o_fwd_sel = FWD_RF;
        if (w_ex_match && !i_ex_mem_rd) begin
            o_fwd_sel = FWD_EX;
        end else if (w_ma_match) begin
            o_fwd_sel = FWD_MA;
        end
    end
`else
    logic w_unused_mem_rd;

    assign w_unused_mem_rd = i_ex_mem_rd;
    assign o_stall_req     = i_rs_used && (w_ex_match || w_ma_match);
    assign o_fwd_sel       = FWD_RF;
`endif

endmodule

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
// ============================================================================
// Module      : pipeline_hazard_ctrl
// Description : Stall/flush/forwarding controller for a 5-stage pipeline with
//               saturating stall and flush event counters.
//               Optional feature macro: HAZARD_FORWARDING_EN
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                clk_en,
    input  logic [REG_ADDR-1:0] i_id_rs1,
    input  logic [REG_ADDR-1:0] i_id_rs2,
    input  logic                i_id_rs1_used,
    input  logic                i_id_rs2_used,
    input  logic [REG_ADDR-1:0] i_ex_rd,
    input  logic                i_ex_reg_wr,
    input  logic                i_ex_mem_rd,
    input  logic [REG_ADDR-1:0] i_ma_rd,
    input  logic                i_ma_reg_wr,
    input  logic                i_ex_redirect,
    input  logic                i_dmem_busy,
    output logic                o_pc_stall,
    output logic                o_if_stall,
    output logic                o_id_bubble,
    output logic                o_if_flush,
    output logic                o_id_flush,
    output logic                o_ex_stall,
    output logic [1:0]          o_fwd_a,
    output logic [1:0]          o_fwd_b,
    output logic [CNT_W-1:0]    o_stall_cnt,
    output logic [CNT_W-1:0]    o_flush_cnt
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    state_t           r_state;
    state_t           w_next_state;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    fwd_sel_t         w_fwd_a;
    fwd_sel_t         w_fwd_b;
    logic             w_stall_a;
    logic             w_stall_b;
    logic             w_hazard;
    logic             w_redirect_acc;
    logic             w_any_stall;

    hazard_compare u_cmp_a (
        .i_rs        (i_id_rs1),
        .i_rs_used   (i_id_rs1_used),
        .i_ex_rd     (i_ex_rd),
        .i_ex_reg_wr (i_ex_reg_wr),
        .i_ex_mem_rd (i_ex_mem_rd),
        .i_ma_rd     (i_ma_rd),
        .i_ma_reg_wr (i_ma_reg_wr),
        .o_fwd_sel   (w_fwd_a),
        .o_stall_req (w_stall_a)
    );

    hazard_compare u_cmp_b (
        .i_rs        (i_id_rs2),
        .i_rs_used   (i_id_rs2_used),
        .i_ex_rd     (i_ex_rd),
        .i_ex_reg_wr (i_ex_reg_wr),
        .i_ex_mem_rd (i_ex_mem_rd),
        .i_ma_rd     (i_ma_rd),
        .i_ma_reg_wr (i_ma_reg_wr),
        .o_fwd_sel   (w_fwd_b),
        .o_stall_req (w_stall_b)
    );

    assign w_hazard = w_stall_a || w_stall_b;
    assign o_fwd_a  = rst ? FWD_RF : w_fwd_a;
    assign o_fwd_b  = rst ? FWD_RF : w_fwd_b;

    // Priority: reset, memory wait, FLUSH tail, redirect, data hazard.
    // MEMWAIT with memory ready falls through and is evaluated like RUN.
    always_comb begin
        o_pc_stall     = 1'b0;
        o_if_stall     = 1'b0;
        o_id_bubble    = 1'b0;
        o_if_flush     = 1'b0;
        o_id_flush     = 1'b0;
        o_ex_stall     = 1'b0;
        w_redirect_acc = 1'b0;
        w_next_state   = RUN;
        if (rst) begin
            w_next_state = RUN;
        end else if (i_dmem_busy) begin
            o_pc_stall   = 1'b1;
            o_if_stall   = 1'b1;
            o_ex_stall   = 1'b1;
            w_next_state = MEMWAIT;
        end else if (r_state == FLUSH) begin
            // ID already holds a squashed slot; only the in-flight fetch is dropped
            o_if_flush = 1'b1;
            if (i_ex_redirect) begin
                w_redirect_acc = 1'b1;
                w_next_state   = FLUSH;
            end
        end else if (i_ex_redirect) begin
            o_if_flush     = 1'b1;
            o_id_flush     = 1'b1;
            w_redirect_acc = 1'b1;
            w_next_state   = FLUSH;
        end else if (w_hazard) begin
            o_pc_stall  = 1'b1;
            o_if_stall  = 1'b1;
            o_id_bubble = 1'b1;
        end
    end

    assign w_any_stall = o_pc_stall || o_if_stall || o_ex_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= RUN;
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (clk_en) begin
            r_state <= w_next_state;
            if (w_any_stall && (r_stall_cnt != c_CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (w_redirect_acc && (r_flush_cnt != c_CNT_MAX)) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    assign o_stall_cnt = r_stall_cnt;
    assign o_flush_cnt = r_flush_cnt;

endmodule

`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
// ============================================================================
// Module      : tb_pipeline_hazard_ctrl
// Description : Self-checking bench for pipeline_hazard_ctrl; expectations
//               follow the HAZARD_FORWARDING_EN setting of the build.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipeline_hazard_ctrl;

`ifdef HAZARD_FORWARDING_EN
    localparam bit c_FWD_ON = 1'b1;
`else
    localparam bit c_FWD_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        clk_en;
    logic [4:0]  i_id_rs1, i_id_rs2, i_ex_rd, i_ma_rd;
    logic        i_id_rs1_used, i_id_rs2_used;
    logic        i_ex_reg_wr, i_ex_mem_rd, i_ma_reg_wr;
    logic        i_ex_redirect, i_dmem_busy;
    logic        o_pc_stall, o_if_stall, o_id_bubble;
    logic        o_if_flush, o_id_flush, o_ex_stall;
    logic [1:0]  o_fwd_a, o_fwd_b;
    logic [15:0] o_stall_cnt, o_flush_cnt;

    int checks = 0;
    int errors = 0;

    pipeline_hazard_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .clk_en        (clk_en),
        .i_id_rs1      (i_id_rs1),
        .i_id_rs2      (i_id_rs2),
        .i_id_rs1_used (i_id_rs1_used),
        .i_id_rs2_used (i_id_rs2_used),
        .i_ex_rd       (i_ex_rd),
        .i_ex_reg_wr   (i_ex_reg_wr),
        .i_ex_mem_rd   (i_ex_mem_rd),
        .i_ma_rd       (i_ma_rd),
        .i_ma_reg_wr   (i_ma_reg_wr),
        .i_ex_redirect (i_ex_redirect),
        .i_dmem_busy   (i_dmem_busy),
        .o_pc_stall    (o_pc_stall),
        .o_if_stall    (o_if_stall),
        .o_id_bubble   (o_id_bubble),
        .o_if_flush    (o_if_flush),
        .o_id_flush    (o_id_flush),
        .o_ex_stall    (o_ex_stall),
        .o_fwd_a       (o_fwd_a),
        .o_fwd_b       (o_fwd_b),
        .o_stall_cnt   (o_stall_cnt),
        .o_flush_cnt   (o_flush_cnt)
    );

    always #5 clk = ~clk;

    // {pc_stall, if_stall, id_bubble, if_flush, id_flush, ex_stall, fwd_a, fwd_b}
    logic [9:0] w_out;
    assign w_out = {o_pc_stall, o_if_stall, o_id_bubble, o_if_flush, o_id_flush,
                    o_ex_stall, o_fwd_a, o_fwd_b};

    typedef struct {
        logic [4:0] rs1, rs2;
        logic       u1, u2;
        logic [4:0] ex_rd;
        logic       ex_wr, ex_ld;
        logic [4:0] ma_rd;
        logic       ma_wr, redir, busy;
        logic [9:0] exp_f;
        logic [9:0] exp_nf;
    } vec_t;

    vec_t vecs[11];

    function automatic vec_t mk(input logic [4:0] rs1, input logic u1,
                                input logic [4:0] rs2, input logic u2,
                                input logic [4:0] ex_rd, input logic ex_wr, input logic ex_ld,
                                input logic [4:0] ma_rd, input logic ma_wr,
                                input logic redir, input logic busy,
                                input logic [9:0] exp_f, input logic [9:0] exp_nf);
        vec_t v;
        v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2;
        v.ex_rd = ex_rd; v.ex_wr = ex_wr; v.ex_ld = ex_ld;
        v.ma_rd = ma_rd; v.ma_wr = ma_wr; v.redir = redir; v.busy = busy;
        v.exp_f = exp_f; v.exp_nf = exp_nf;
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic clear_in();
        i_id_rs1 = 5'd0; i_id_rs2 = 5'd0; i_id_rs1_used = 1'b0; i_id_rs2_used = 1'b0;
        i_ex_rd = 5'd0; i_ex_reg_wr = 1'b0; i_ex_mem_rd = 1'b0;
        i_ma_rd = 5'd0; i_ma_reg_wr = 1'b0;
        i_ex_redirect = 1'b0; i_dmem_busy = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 10'b000000_00_00, 10'b000000_00_00);
        vecs[1]  = mk(7, 1, 0, 0, 7, 1, 1, 0, 0, 0, 0, 10'b111000_00_00, 10'b111000_00_00);
        vecs[2]  = mk(1, 1, 5, 1, 5, 1, 0, 5, 1, 0, 0, 10'b000000_00_01, 10'b111000_00_00);
        vecs[3]  = mk(0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 10'b000000_00_00, 10'b000000_00_00);
        vecs[4]  = mk(9, 1, 0, 0, 0, 0, 0, 9, 1, 0, 0, 10'b000000_10_00, 10'b111000_00_00);
        vecs[5]  = mk(4, 1, 4, 1, 4, 1, 0, 0, 0, 0, 0, 10'b000000_01_01, 10'b111000_00_00);
        vecs[6]  = mk(0, 0, 6, 0, 6, 1, 1, 0, 0, 0, 0, 10'b000000_00_00, 10'b000000_00_00);
        vecs[7]  = mk(7, 1, 0, 0, 7, 1, 1, 0, 0, 1, 0, 10'b000110_00_00, 10'b000110_00_00);
        vecs[8]  = mk(7, 1, 0, 0, 7, 1, 1, 0, 0, 1, 1, 10'b110001_00_00, 10'b110001_00_00);
        vecs[9]  = mk(8, 1, 0, 0, 8, 0, 0, 8, 1, 0, 0, 10'b000000_10_00, 10'b111000_00_00);
        vecs[10] = mk(3, 1, 0, 0, 3, 1, 1, 3, 1, 0, 0, 10'b111000_10_00, 10'b111000_00_00);

        // Reset: outputs forced low while rst is high, even with hazards present
        clear_in();
        rst = 1'b1; clk_en = 1'b1;
        i_dmem_busy = 1'b1; i_ex_redirect = 1'b1;
        i_id_rs1 = 5'd2; i_id_rs1_used = 1'b1; i_ex_rd = 5'd2; i_ex_reg_wr = 1'b1;
        @(negedge clk);
        chk("reset_outputs", {6'd0, w_out}, 16'd0);
        tick();
        chk("reset_stall_cnt", o_stall_cnt, 16'd0);
        chk("reset_flush_cnt", o_flush_cnt, 16'd0);
        rst = 1'b0;
        clear_in();

        // Table: clk_en=0 keeps state RUN and counters frozen; outputs stay live
        clk_en = 1'b0;
        for (int i = 0; i < 11; i++) begin
            i_id_rs1 = vecs[i].rs1; i_id_rs1_used = vecs[i].u1;
            i_id_rs2 = vecs[i].rs2; i_id_rs2_used = vecs[i].u2;
            i_ex_rd = vecs[i].ex_rd; i_ex_reg_wr = vecs[i].ex_wr; i_ex_mem_rd = vecs[i].ex_ld;
            i_ma_rd = vecs[i].ma_rd; i_ma_reg_wr = vecs[i].ma_wr;
            i_ex_redirect = vecs[i].redir; i_dmem_busy = vecs[i].busy;
            @(negedge clk);
            chk($sformatf("vec%0d", i), {6'd0, w_out},
                {6'd0, (c_FWD_ON ? vecs[i].exp_f : vecs[i].exp_nf)});
            tick();
        end
        chk("hold_stall_cnt", o_stall_cnt, 16'd0);
        chk("hold_flush_cnt", o_flush_cnt, 16'd0);
        clk_en = 1'b1;
        clear_in();
        do_reset();

        // Load-use: one stall cycle, then MA forward (or continued stall)
        i_id_rs1 = 5'd7; i_id_rs1_used = 1'b1;
        i_ex_rd = 5'd7; i_ex_reg_wr = 1'b1; i_ex_mem_rd = 1'b1;
        @(negedge clk);
        chk("lu_c0_out", {6'd0, w_out}, {6'd0, 10'b111000_00_00});
        chk("lu_c0_cnt", o_stall_cnt, 16'd0);
        tick();
        chk("lu_c1_cnt", o_stall_cnt, 16'd1);
        i_ex_rd = 5'd0; i_ex_reg_wr = 1'b0; i_ex_mem_rd = 1'b0;
        i_ma_rd = 5'd7; i_ma_reg_wr = 1'b1;
        @(negedge clk);
        chk("lu_c1_out", {6'd0, w_out},
            {6'd0, (c_FWD_ON ? 10'b000000_10_00 : 10'b111000_00_00)});
        clear_in();
        do_reset();

        // Redirect pulse in RUN
        i_ex_redirect = 1'b1;
        @(negedge clk);
        chk("rd_c0", {6'd0, w_out}, {6'd0, 10'b000110_00_00});
        tick();
        i_ex_redirect = 1'b0;
        @(negedge clk);
        chk("rd_c1", {6'd0, w_out}, {6'd0, 10'b000100_00_00});
        tick();
        @(negedge clk);
        chk("rd_c2", {6'd0, w_out}, 16'd0);
        chk("rd_flush_cnt", o_flush_cnt, 16'd1);
        do_reset();

        // Busy for 3 cycles masks a coincident redirect
        i_dmem_busy = 1'b1; i_ex_redirect = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk($sformatf("mw_c%0d", c), {6'd0, w_out}, {6'd0, 10'b110001_00_00});
            tick();
        end
        chk("mw_flush_cnt0", o_flush_cnt, 16'd0);
        i_dmem_busy = 1'b0;
        @(negedge clk);
        chk("mw_release", {6'd0, w_out}, {6'd0, 10'b000110_00_00});
        tick();
        i_ex_redirect = 1'b0;
        @(negedge clk);
        chk("mw_flush_tail", {6'd0, w_out}, {6'd0, 10'b000100_00_00});
        chk("mw_stall_cnt", o_stall_cnt, 16'd3);
        chk("mw_flush_cnt1", o_flush_cnt, 16'd1);
        clear_in();
        do_reset();

        // RAW on an ALU result: forwarded, or stalled until MA retires it
        i_id_rs1 = 5'd3; i_id_rs1_used = 1'b1; i_ex_rd = 5'd3; i_ex_reg_wr = 1'b1;
        @(negedge clk);
        chk("raw_c0", {6'd0, w_out},
            {6'd0, (c_FWD_ON ? 10'b000000_01_00 : 10'b111000_00_00)});
        tick();
        i_ex_rd = 5'd0; i_ex_reg_wr = 1'b0; i_ma_rd = 5'd3; i_ma_reg_wr = 1'b1;
        @(negedge clk);
        chk("raw_c1", {6'd0, w_out},
            {6'd0, (c_FWD_ON ? 10'b000000_10_00 : 10'b111000_00_00)});
        tick();
        i_ma_rd = 5'd0; i_ma_reg_wr = 1'b0;
        @(negedge clk);
        chk("raw_c2", {6'd0, w_out}, 16'd0);
        chk("raw_stall_cnt", o_stall_cnt, (c_FWD_ON ? 16'd0 : 16'd2));
        clear_in();
        do_reset();

        // Saturation, then reset out of FLUSH
        i_dmem_busy = 1'b1;
        repeat (70000) tick();
        chk("sat_stall_cnt", o_stall_cnt, 16'hFFFF);
        i_dmem_busy = 1'b0; i_ex_redirect = 1'b1;
        tick();
        i_ex_redirect = 1'b0;
        @(negedge clk);
        chk("sat_in_flush", {6'd0, w_out}, {6'd0, 10'b000100_00_00});
        chk("sat_flush_cnt", o_flush_cnt, 16'd1);
        rst = 1'b1;
        #1;
        chk("rst_mask_flush", {6'd0, w_out}, 16'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rst_state_run", {6'd0, w_out}, 16'd0);
        chk("rst_stall_cnt", o_stall_cnt, 16'd0);
        chk("rst_flush_cnt", o_flush_cnt, 16'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
